// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, decode/emit state encodings and the scan-code to ASCII map
// for the PS/2 key decoder.
package ps2_key_decoder_pkg;

   localparam int unsigned FRAME_BITS = 11;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   typedef logic [1:0] decode_state_t;
   localparam decode_state_t D_IDLE      = 2'd0;
   localparam decode_state_t D_BREAK     = 2'd1;
   localparam decode_state_t D_EXT       = 2'd2;
   localparam decode_state_t D_EXT_BREAK = 2'd3;

   typedef logic [1:0] emit_state_t;
   localparam emit_state_t E_IDLE = 2'd0;
   localparam emit_state_t E_CHAR = 2'd1;
   localparam emit_state_t E_ADV  = 2'd2;
   localparam emit_state_t E_CLR  = 2'd3;

   function automatic logic is_shift(input logic [7:0] code);
      return (code == SC_LSHIFT) || (code == SC_RSHIFT);
   endfunction

   // Returns 0 for codes outside the renderer's glyph set.
   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
      logic [7:0] ch;
      ch = 8'h00;
      case (code)
         8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
         8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
         8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
         8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
         8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
         8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
         8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
         8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;
         8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;
         8'h3E: ch = 8'h38;  8'h46: ch = 8'h39;
         8'h29: ch = 8'h20;
         8'h4E: ch = 8'h2D;
         8'h55: ch = 8'h3D;
         8'h5D: ch = shift ? 8'h7C : 8'h00;
         default: ch = 8'h00;
      endcase
      if (shift && (ch >= 8'h61) && (ch <= 8'h7A))
         ch = ch - 8'h20;
      return ch;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and renderer-facing outputs of the key decoder.
interface ps2_key_decoder_if;
   logic       iPS2_CLK;
   logic       iPS2_DAT;
   logic [7:0] oKeyChar;
   logic       oAdvanceCursor;
   logic       oParityErr;
   logic       oOverrun;

   modport master (
      output iPS2_CLK, iPS2_DAT,
      input  oKeyChar, oAdvanceCursor, oParityErr, oOverrun
   );

   modport slave (
      input  iPS2_CLK, iPS2_DAT,
      output oKeyChar, oAdvanceCursor, oParityErr, oOverrun
   );
endinterface

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: line synchronisers, bit counter with inter-bit timeout,
// start/stop/parity check. Emits one-cycle valid or err pulses.
module ps2_frame_rx
   import ps2_key_decoder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] data,
   output logic       valid,
   output logic       err
);

   localparam int unsigned TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);

   logic [2:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [TW-1:0] timer;
   logic          fall;
   logic [10:0]   frame;

   assign fall  = clk_sync[2] & ~clk_sync[1];
   // The stop bit is taken straight from the synchroniser so the check happens on its own fall.
   assign frame = {dat_sync[1], shreg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= '1;
         dat_sync <= '1;
         bit_cnt  <= '0;
         shreg    <= '0;
         timer    <= '0;
         data     <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[1:0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
         valid    <= 1'b0;
         err      <= 1'b0;
         if (fall) begin
            timer <= '0;
            if (bit_cnt == LAST_BIT) begin
               bit_cnt <= '0;
               if (!frame[0] && frame[10] && (^frame[9:1])) begin
                  valid <= 1'b1;
                  data  <= frame[8:1];
               end else begin
                  err <= 1'b1;
               end
            end else begin
               shreg   <= {dat_sync[1], shreg[9:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != '0) begin
            if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
               bit_cnt <= '0;
               timer   <= '0;
            end else begin
               timer <= timer + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to character-stream decoder for the text renderer.
// Optional PS2_REPEAT_FILTER_EN suppresses typematic repeats of the held key.
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 25_000_000,
   parameter int unsigned TIMEOUT_US = 200,
   parameter int unsigned ADV_PULSE  = 2
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   ps2_key_decoder_if.slave  bus
);

   localparam int unsigned TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int unsigned AW = (ADV_PULSE > 1) ? $clog2(ADV_PULSE) : 1;

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_err;

   decode_state_t d_state;
   logic          shift_on;
   logic          new_valid;
   logic [7:0]    new_char;

   emit_state_t   e_state;
   logic [AW-1:0] adv_cnt;
   logic [7:0]    key_char;
   logic          adv;
   logic          overrun;
   logic          hold_valid;
   logic [7:0]    hold_char;
   logic          take_hold;
   logic          take_new;

`ifdef PS2_REPEAT_FILTER_EN
   logic [7:0]    last_key;
`endif

   ps2_frame_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk     (iVGA_CLK),
      .rst_n   (iRST_n),
      .ps2_clk (bus.iPS2_CLK),
      .ps2_dat (bus.iPS2_DAT),
      .data    (rx_data),
      .valid   (rx_valid),
      .err     (rx_err)
   );

   // Prefix and shift codes all map to 0, so a nonzero translation implies a printable make.
   always_comb begin
      new_char  = scan_to_ascii(rx_data, shift_on);
      new_valid = rx_valid && (d_state == D_IDLE) && (new_char != 8'h00);
`ifdef PS2_REPEAT_FILTER_EN
      if (rx_data == last_key)
         new_valid = 1'b0;
`endif
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         d_state  <= D_IDLE;
         shift_on <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
         last_key <= '0;
`endif
      end else if (rx_valid) begin
         case (d_state)
            D_IDLE: begin
               if (rx_data == SC_BREAK) begin
                  d_state <= D_BREAK;
               end else if (rx_data == SC_EXT) begin
                  d_state <= D_EXT;
               end else begin
                  if (is_shift(rx_data))
                     shift_on <= 1'b1;
`ifdef PS2_REPEAT_FILTER_EN
                  last_key <= rx_data;
`endif
               end
            end
            D_BREAK: begin
               if (is_shift(rx_data))
                  shift_on <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
               if (rx_data == last_key)
                  last_key <= '0;
`endif
               d_state <= D_IDLE;
            end
            D_EXT:   d_state <= (rx_data == SC_BREAK) ? D_EXT_BREAK : D_IDLE;
            default: d_state <= D_IDLE;
         endcase
      end
   end

   // An idle emitter takes a fresh character directly so oKeyChar follows acceptance by one cycle.
   assign take_hold = (e_state == E_IDLE) && hold_valid;
   assign take_new  = (e_state == E_IDLE) && !hold_valid && new_valid;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         e_state    <= E_IDLE;
         adv_cnt    <= '0;
         key_char   <= '0;
         adv        <= 1'b0;
         overrun    <= 1'b0;
         hold_valid <= 1'b0;
         hold_char  <= '0;
      end else begin
         overrun <= 1'b0;
         case (e_state)
            E_IDLE: begin
               if (hold_valid) begin
                  key_char <= hold_char;
                  e_state  <= E_CHAR;
               end else if (new_valid) begin
                  key_char <= new_char;
                  e_state  <= E_CHAR;
               end
            end
            E_CHAR: begin
               adv     <= 1'b1;
               adv_cnt <= '0;
               e_state <= E_ADV;
            end
            E_ADV: begin
               if (adv_cnt == AW'(ADV_PULSE - 1)) begin
                  adv      <= 1'b0;
                  key_char <= '0;
                  e_state  <= E_CLR;
               end else begin
                  adv_cnt <= adv_cnt + 1'b1;
               end
            end
            default: e_state <= E_IDLE;
         endcase

         if (take_hold)
            hold_valid <= 1'b0;
         if (new_valid && !take_new) begin
            if (hold_valid && !take_hold) begin
               overrun <= 1'b1;
            end else begin
               hold_valid <= 1'b1;
               hold_char  <= new_char;
            end
         end
      end
   end

   assign bus.oKeyChar       = key_char;
   assign bus.oAdvanceCursor = adv;
   assign bus.oParityErr     = rx_err;
   assign bus.oOverrun       = overrun;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random scan-code
// traffic compared against a table-driven keyboard model.
module tb_ps2_key_decoder;

   localparam int unsigned ADV_P = 3;
   localparam int HALF = 10;
`ifdef PS2_REPEAT_FILTER_EN
   localparam int REP_EXP = 1;
`else
   localparam int REP_EXP = 3;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   ps2_key_decoder_if bus();

   ps2_key_decoder #(
      .CLK_HZ     (1_000_000),
      .TIMEOUT_US (200),
      .ADV_PULSE  (ADV_P)
   ) dut (
      .iVGA_CLK (clk),
      .iRST_n   (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference keyboard model ----------------
   logic [7:0] letter_code [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                     8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                     8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
   logic [7:0] digit_code  [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
   logic [7:0] extra_code  [8]  = '{8'h29,8'h4E,8'h55,8'h5D,8'h12,8'h59,8'hF0,8'hE0};

   logic [7:0] exp_q [$];
   bit         m_shift, m_brk, m_ext;
   logic [7:0] m_last;
   int         err_exp = 0;
   int         fall_cyc = 0;

   function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit sh);
      for (int i = 0; i < 26; i++)
         if (letter_code[i] == c) return sh ? 8'(65 + i) : 8'(97 + i);
      for (int i = 0; i < 10; i++)
         if (digit_code[i] == c) return 8'(48 + i);
      if (c == 8'h29) return 8'h20;
      if (c == 8'h4E) return 8'h2D;
      if (c == 8'h55) return 8'h3D;
      if (c == 8'h5D && sh) return 8'h7C;
      return 8'h00;
   endfunction

   task automatic model_reset();
      m_shift = 0; m_brk = 0; m_ext = 0; m_last = 8'h00;
      exp_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] ch;
      bit         rep;
      if (m_ext) begin
         if (!m_brk && b == 8'hF0) m_brk = 1;
         else begin m_ext = 0; m_brk = 0; end
      end else if (m_brk) begin
         if (b == 8'h12 || b == 8'h59) m_shift = 0;
         if (b == m_last) m_last = 8'h00;
         m_brk = 0;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else begin
         if (b == 8'h12 || b == 8'h59) m_shift = 1;
         ch = ref_ascii(b, m_shift);
`ifdef PS2_REPEAT_FILTER_EN
         rep = (b == m_last);
`else
         rep = 0;
`endif
         m_last = b;
         if (ch != 8'h00 && !rep) exp_q.push_back(ch);
      end
   endtask

   // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop; nbits < 11 sends a truncated frame
   task automatic send_frame(input logic [7:0] b, input int kind, input int nbits);
      logic [10:0] f;
      f = {1'b1, ~^b, b, 1'b0};
      if (kind == 1) f[9] = ~f[9];
      if (kind == 2) f[0] = 1'b1;
      if (kind == 3) f[10] = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) bus.iPS2_DAT = f[i];
         repeat (HALF) @(negedge clk);
         if (i == 10) begin
            if (kind == 0) model_byte(b);
            else err_exp++;
            fall_cyc = cyc;
         end
         bus.iPS2_CLK = 1'b0;
         repeat (HALF) @(negedge clk);
         bus.iPS2_CLK = 1'b1;
      end
      bus.iPS2_DAT = 1'b1;
   endtask

   task automatic send_seq(input logic [7:0] s [$]);
      foreach (s[i]) send_frame(s[i], 0, 11);
      repeat (20) @(negedge clk);
   endtask

   function automatic logic [7:0] pick_code();
      int r;
      r = $urandom_range(0, 99);
      if (r < 45) return letter_code[$urandom_range(0, 25)];
      if (r < 65) return digit_code[$urandom_range(0, 9)];
      if (r < 92) return extra_code[$urandom_range(0, 7)];
      return 8'($urandom_range(0, 255));
   endfunction

   // ---------------- output monitor ----------------
   int         mon_phase = 0;
   int         mon_cnt = 0;
   logic [7:0] cur_char;
   int         emit_cnt = 0;
   logic [7:0] last_char = 8'h00;
   int         err_seen = 0;
   int         ovr_seen = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_phase = 0;
      end else begin
         if (bus.oParityErr) err_seen++;
         if (bus.oOverrun) ovr_seen++;
         case (mon_phase)
            0: begin
               if (bus.oKeyChar != 8'h00) begin
                  if (exp_q.size() == 0) check("extra_char", 32'(bus.oKeyChar), 32'h0);
                  else check("char", 32'(bus.oKeyChar), 32'(exp_q.pop_front()));
                  check("latency", 32'(cyc - fall_cyc), 32'd4);
                  check("adv_early", 32'(bus.oAdvanceCursor), 32'd0);
                  cur_char  = bus.oKeyChar;
                  last_char = bus.oKeyChar;
                  emit_cnt++;
                  mon_cnt   = 0;
                  mon_phase = 1;
               end else if (bus.oAdvanceCursor) begin
                  check("adv_idle", 32'(bus.oAdvanceCursor), 32'd0);
               end
            end
            1: begin
               check("adv_pulse", {23'd0, bus.oAdvanceCursor, bus.oKeyChar}, {23'd0, 1'b1, cur_char});
               mon_cnt++;
               if (mon_cnt == ADV_P) mon_phase = 2;
            end
            default: begin
               check("clr", {23'd0, bus.oAdvanceCursor, bus.oKeyChar}, 32'd0);
               mon_phase = 0;
            end
         endcase
      end
   end

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: cycle budget expired");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int e0, r;
      bus.iPS2_CLK = 1'b1;
      bus.iPS2_DAT = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_char", 32'(bus.oKeyChar), 32'h0);
      check("rst_adv",  32'(bus.oAdvanceCursor), 32'h0);
      check("rst_perr", 32'(bus.oParityErr), 32'h0);
      check("rst_ovr",  32'(bus.oOverrun), 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      e0 = emit_cnt;
      send_seq('{8'h1C});
      check("a_char", 32'(last_char), 32'h61);
      check("a_count", 32'(emit_cnt - e0), 32'd1);

      send_seq('{8'h12, 8'h33});
      check("shift_H", 32'(last_char), 32'h48);
      e0 = emit_cnt;
      send_seq('{8'hF0, 8'h33, 8'hF0, 8'h12, 8'h33});
      check("unshift_h", 32'(last_char), 32'h68);
      check("unshift_count", 32'(emit_cnt - e0), 32'd1);

      e0 = emit_cnt;
      send_frame(8'h1C, 1, 11);
      repeat (20) @(negedge clk);
      check("perr_pulse", 32'(err_seen), 32'(err_exp));
      check("perr_nochar", 32'(emit_cnt - e0), 32'd0);

      e0 = emit_cnt;
      send_frame(8'h1C, 0, 4);
      repeat (250) @(negedge clk);
      send_seq('{8'h16});
      check("timeout_char", 32'(last_char), 32'h31);
      check("timeout_count", 32'(emit_cnt - e0), 32'd1);

      e0 = emit_cnt;
      send_seq('{8'h1C, 8'h1C, 8'h1C});
      check("repeat_count", 32'(emit_cnt - e0), 32'(REP_EXP));
      send_seq('{8'hF0, 8'h1C});

      e0 = emit_cnt;
      send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
      check("ext_silent", 32'(emit_cnt - e0), 32'd0);
      send_seq('{8'h29});
      check("space", 32'(last_char), 32'h20);

      // reset in the middle of a frame
      send_frame(8'h32, 0, 5);
      rst_n = 1'b0;
      #1;
      check("rstf_char", 32'(bus.oKeyChar), 32'h0);
      check("rstf_adv", 32'(bus.oAdvanceCursor), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      send_seq('{8'h32});
      check("after_rstf", 32'(last_char), 32'h62);

      // reset in the middle of the advance pulse
      fork
         send_frame(8'h3A, 0, 11);
      join_none
      for (int k = 0; k < 400 && bus.oKeyChar == 8'h00; k++) @(negedge clk);
      check("rste_started", 32'(bus.oKeyChar != 8'h00), 32'd1);
      @(negedge clk);
      check("rste_adv_hi", 32'(bus.oAdvanceCursor), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rste_char", 32'(bus.oKeyChar), 32'h0);
      check("rste_adv", 32'(bus.oAdvanceCursor), 32'h0);
      wait fork;
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);

      for (int n = 0; n < 45; n++) begin
         r = $urandom_range(0, 99);
         if (r < 8) begin
            send_frame(8'($urandom_range(0, 255)), $urandom_range(1, 3), 11);
         end else if (r < 14) begin
            send_frame(8'($urandom_range(0, 255)), 0, $urandom_range(1, 10));
            repeat (250) @(negedge clk);
         end else begin
            send_frame(pick_code(), 0, 11);
         end
      end

      repeat (30) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("perr_total", 32'(err_seen), 32'(err_exp));
      check("overrun_none", 32'(ovr_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
